// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, latency constants and FSM state type for the MDU.
//   OP_*            : 3-bit op codes driven on mdu_ctrl.op (6-7 reserved)
//   MDU_*_CYCLES    : default busy-window lengths for multiply and divide
//   mdu_state_t     : controller FSM state
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    typedef enum logic {IDLE, RUN} mdu_state_t;

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational multiply/divide datapath producing the pending HI/LO pair.
//   op               : MDU op code (only MULT/MULTU/DIV/DIVU are meaningful here)
//   rs_val, rt_val   : operands (multiplicand/dividend, multiplier/divisor)
//   hi, lo           : current HI/LO, reused as the result when dividing by zero
//   pend_hi, pend_lo : product high/low, or remainder/quotient
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] pend_hi,
    output logic [31:0] pend_lo
);

    logic        is_div, is_signed, a_neg, b_neg;
    logic [31:0] ua, ub, uq, ur, q, r;
    logic [63:0] prod;

    // Signed division is done on magnitudes so the 0x80000000 / -1 case
    // wraps cleanly to 0x80000000 instead of relying on an overflowing divide.
    always_comb begin
        is_div    = (op == OP_DIV) || (op == OP_DIVU);
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        prod      = is_signed ? {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val}
                              : {32'd0, rs_val} * {32'd0, rt_val};
        a_neg     = is_signed & rs_val[31];
        b_neg     = is_signed & rt_val[31];
        ua        = a_neg ? 32'(-rs_val) : rs_val;
        ub        = b_neg ? 32'(-rt_val) : rt_val;
        uq        = (ub == 32'd0) ? 32'd0 : ua / ub;
        ur        = (ub == 32'd0) ? 32'd0 : ua % ub;
        q         = (a_neg ^ b_neg) ? 32'(-uq) : uq;
        r         = a_neg ? 32'(-ur) : ur;
        pend_hi   = !is_div ? prod[63:32] : (rt_val == 32'd0) ? hi : r;
        pend_lo   = !is_div ? prod[31:0]  : (rt_val == 32'd0) ? lo : q;
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide controller with fixed-latency busy window and HI/LO.
//   clk, reset       : clock, synchronous active-high reset
//   start, op        : MDU operation valid in E and its op code
//   rs_val, rt_val   : forwarded operands
//   cancel           : older instruction in M faulted; blocks acceptance only
//   busy             : operation in flight
//   stall_req        : hold MDU/MF instructions in D (combinational)
//   done             : one-cycle pulse when a MULT/DIV result lands in HI/LO
//   hi, lo           : architectural HI/LO registers
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    mdu_state_t  state;
    logic [CW-1:0] cnt;
    logic [31:0] pend_hi, pend_lo, a_hi, a_lo;
    logic        accept;

    mdu_arith u_arith (
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .hi      (hi),
        .lo      (lo),
        .pend_hi (a_hi),
        .pend_lo (a_lo)
    );

    assign busy      = (state == RUN);
    assign accept    = start && !cancel && (state == IDLE) && (op <= OP_MTLO);
    assign stall_req = busy || (start && (op <= OP_DIVU) && !cancel);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (op == OP_MTHI) hi <= rs_val;
                    else if (op == OP_MTLO) lo <= rs_val;
                    else begin
                        pend_hi <= a_hi;
                        pend_lo <= a_lo;
                        cnt     <= (op == OP_DIV || op == OP_DIVU) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state   <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    // Commit on the edge the counter reaches zero.
                    if (cnt == CW'(1)) begin
                        hi    <= pend_hi;
                        lo    <= pend_lo;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: self-checking bench for mdu_ctrl with a completion-time model and literal checks.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        cancel = 1'b0;
    logic        busy, stall_req, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    mdu_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .cancel    (cancel),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an MDU op computed with wide integer arithmetic.
    function automatic logic [63:0] mdu_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] h,
                                               input logic [31:0] l);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = {h, l};
        case (o)
            3'd0: res = 64'(sa * sb);
            3'd1: res = {32'd0, a} * {32'd0, b};
            3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            3'd3: if (b != 0) res = {a % b, a / b};
            default: res = {h, l};
        endcase
        return res;
    endfunction

    // Model: each accepted MULT/DIV is an interval ending at edge fin.
    int          e = 0;
    int          fin = -1;
    logic [31:0] mh = 0, ml = 0, ph = 0, pl = 0;

    always @(posedge clk) begin
        e <= e + 1;
        if (reset) begin
            fin <= -1;
            mh  <= 0;
            ml  <= 0;
        end else begin
            if (fin == e + 1) begin
                mh <= ph;
                ml <= pl;
            end
            if (start && !cancel && op <= 5 && !(fin >= 0 && e < fin)) begin
                if (op == 3'd4) mh <= rs_val;
                else if (op == 3'd5) ml <= rs_val;
                else begin
                    {ph, pl} <= mdu_result(op, rs_val, rt_val, mh, ml);
                    fin <= e + 1 + ((op >= 3'd2) ? 10 : 5);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic bx;
            bx = (fin >= 0) && (e < fin);
            chk("m_busy", 32'(busy), 32'(bx));
            chk("m_done", 32'(done), 32'(e == fin));
            chk("m_stall", 32'(stall_req), 32'(bx || (start && op <= 3 && !cancel)));
            chk("m_hi", hi, mh);
            chk("m_lo", lo, ml);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        start = 1'b1; op = o; rs_val = a; rt_val = b; cancel = c;
        step();
        start = 1'b0; cancel = 1'b0;
    endtask

    // Issue and advance to the expected done cycle, then pin it with literals.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] eh,
                          input logic [31:0] el);
        issue(o, a, b, 1'b0);
        chk({name, "_busy1"}, 32'(busy), 32'd1);
        repeat (n) step();
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk_en = 1'b1;
        reset = 1'b0;
        chk("rst_hi", hi, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();

        run_op("mult", 3'd0, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        step();
        run_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
        step();
        run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        step();
        run_op("divu0", 3'd3, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        step();
        run_op("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        step();
        run_op("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        step();

        start = 1'b1; op = 3'd4; rs_val = 32'h12345678; #1;
        chk("mthi_stall", 32'(stall_req), 32'd0);
        step();
        chk("mthi_hi", hi, 32'h12345678);
        op = 3'd5; rs_val = 32'h9ABCDEF0; #1;
        chk("mtlo_stall", 32'(stall_req), 32'd0);
        step();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mt_busy", 32'(busy), 32'd0);
        step();

        start = 1'b1; op = 3'd0; rs_val = 32'd3; rt_val = 32'd3; cancel = 1'b1; #1;
        chk("cancel_stall", 32'(stall_req), 32'd0);
        step();
        start = 1'b0; cancel = 1'b0;
        chk("cancel_busy", 32'(busy), 32'd0);
        chk("cancel_lo", lo, 32'h9ABCDEF0);
        step();

        issue(3'd0, 32'd3, 32'd4, 1'b0);
        step();
        issue(3'd0, 32'd5, 32'd5, 1'b1);
        issue(3'd1, 32'd9, 32'd9, 1'b0);
        step();
        chk("midrun_busy", 32'(busy), 32'd1);
        step();
        chk("midrun_done", 32'(done), 32'd1);
        chk("midrun_lo", lo, 32'd12);
        step();

        start = 1'b1; op = 3'd6; #1;
        chk("rsvd_stall", 32'(stall_req), 32'd0);
        step();
        start = 1'b0;
        chk("rsvd_busy", 32'(busy), 32'd0);

        issue(3'd0, 32'd2, 32'd3, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstrun_busy", 32'(busy), 32'd0);
        chk("rstrun_hi", hi, 32'd0);
        chk("rstrun_lo", lo, 32'd0);
        step();
        chk("rstrun_done", 32'(done), 32'd0);
        step();

        run_op("b2b1", 3'd0, 32'd6, 32'd7, 5, 32'd0, 32'd42);
        issue(3'd0, 32'h00010000, 32'h00010000, 1'b0);
        chk("b2b_busy", 32'(busy), 32'd1);
        repeat (4) step();
        chk("b2b_busy5", 32'(busy), 32'd1);
        step();
        chk("b2b2_done", 32'(done), 32'd1);
        chk("b2b2_hi", hi, 32'd1);
        chk("b2b2_lo", lo, 32'd0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the five-stage MIPS pipeline. It sits beside the ALU in the E stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations, sequences a fixed-latency busy window, and commits results to the HI/LO registers. It also raises a stall request so the hazard unit holds MFHI/MFLO and further MDU instructions in D. Operations issued in E are cancelled when an older instruction in M takes an exception or interrupt.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  valid MDU operation in E this cycle
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved (ignored)
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / MT source)
- rt_val  in  32  forwarded rt operand (divisor / multiplier)
- cancel  in  1  exception or interrupt committed in M this cycle; suppresses start
- busy  out  1  operation in flight
- stall_req  out  1  busy OR (start AND op≤3 AND NOT cancel), combinational
- done  out  1  one-cycle pulse on the cycle HI/LO become valid after a MULT/DIV
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- FSM states: IDLE, RUN. The down-counter width is clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- Accept: start=1, cancel=0, state=IDLE, op≤5. A start in RUN is ignored; it does not queue.
- MULT/MULTU at accept:
  - Compute the 64-bit signed or unsigned product of rs_val×rt_val into pend_hi/pend_lo.
  - Load the counter with MULT_CYCLES; go to RUN.
- DIV/DIVU at accept:
  - pend_lo = quotient, pend_hi = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - If rt_val=0, set pend = current hi/lo, so HI/LO are unchanged after the window.
  - Load the counter with DIV_CYCLES; go to RUN.
  - 0x80000000 / 0xFFFFFFFF signed yields lo=0x80000000, hi=0.
- MTHI/MTLO: write rs_val to hi/lo at the accept edge. No RUN, busy never asserts, done does not pulse.
- RUN: decrement each cycle. On the edge where counter reaches 0:
  - hi<=pend_hi, lo<=pend_lo
  - go to IDLE
  - done=1 for the following cycle
- cancel only blocks acceptance. It does not abort an operation already in RUN, because that operation belongs to an older, committed instruction.
- Reserved op with start: no state change, stall_req=0.

## Timing
- Reset values: state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, pend 0.
- Reset during RUN aborts the operation. Pending results are discarded and hi/lo are cleared at that edge.
- MULT accepted at edge t:
  - busy=1 during cycles t+1 … t+MULT_CYCLES.
  - hi/lo updated at edge t+MULT_CYCLES.
  - busy=0 and done=1 in cycle t+MULT_CYCLES+1.
- DIV follows the same pattern with DIV_CYCLES.
- An MFHI/MFLO read in the same cycle that done=1 sees the new value.
- Back-to-back: a new start is accepted in the cycle busy falls, i.e. the done cycle. Minimum gap between MULT accepts is MULT_CYCLES+1 edges.
- stall_req is high in the accept cycle itself. This lets the hazard unit stall the next MDU/MF instruction without a gap.
- start and cancel in the same cycle: not accepted, stall_req=0, no register change.

## Structure
- Shared package (mdu_pkg): op encodings, MDU_MULT_CYCLES=5 and MDU_DIV_CYCLES=10 constants, and the FSM state typedef.
- Sub-module mdu_arith: purely combinational. Takes op, rs_val, rt_val, hi, lo and produces pend_hi, pend_lo, including the div-by-zero rule.
- mdu_ctrl holds the FSM, counter, pend registers and HI/LO.

## Test plan
- Reset, then MULT with rs=0xFFFFFFFF, rt=2:
  - busy cycles 1–5, done in cycle 6.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - MULTU with the same operands gives hi=1, lo=0xFFFFFFFE.
- DIV with rs=-7 (0xFFFFFFF9), rt=2:
  - after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/0 leaves the prior hi/lo unchanged, and done still pulses at cycle 11.
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 on consecutive cycles:
  - hi and lo are updated at the respective next edge.
  - busy stays 0 and stall_req stays 0.
- start=1, op=MULT, cancel=1:
  - no busy, stall_req=0, hi/lo unchanged.
  - A MULT issued mid-RUN with cancel=1 does not affect the running op.
- MULT accepted, then reset asserted at busy cycle 3: next cycle busy=0, hi=lo=0, no done pulse.
- MULT issued again in its own done cycle: accepted, busy stays high for 5 more cycles, and the second result is committed.
